pipelined_tree_adder: RTL and testbench
=======================================

// Module: pipelined_tree_adder
// PURPOSE
//   Parametrised, pipelined signed reduction adder. Sums N_IN packed signed operands per
//   beat through a registered binary tree, one register level per tree level.
//   Optionally accumulates successive beats into one frame sum, and wraps or saturates
//   the result to OUT_W. Sits between a product array and the result writer, and uses
//   valid/ready handshakes on both sides.
// PARAMETERS
//   N_IN    32  operand count per beat; power of two, 2..64
//   IN_W    36  operand width, signed two's complement
//   OUT_W   32  result width, signed; OUT_W <= IN_W+LOG2(N_IN)+ACC_EXT
//   ACC_EXT 8   accumulator headroom bits above the tree width
//   SAT     0   0 = wrap (truncate to OUT_W), 1 = saturate to the signed OUT_W range
//   Derived: LEVELS = log2(N_IN); TREE_W = IN_W+LEVELS; ACC_W = TREE_W+ACC_EXT
// PORTS
//   clk       in   1          clock, rising edge
//   rst_n     in   1          asynchronous reset, active low
//   in_valid  in   1          in_data/in_last/acc_en hold a beat
//   in_ready  out  1          block accepts the beat this cycle
//   in_data   in   N_IN*IN_W  operand k at [k*IN_W +: IN_W], k = 0..N_IN-1
//   in_last   in   1          last beat of an accumulation frame (ignored when acc_en=0)
//   acc_en    in   1          per-beat mode: 0 = emit each beat's sum, 1 = accumulate
//   out_valid out  1          out_data/out_ovf are valid
//   out_ready in   1          consumer takes the result this cycle
//   out_data  out  OUT_W      converted sum
//   out_ovf   out  1          full-precision value did not fit OUT_W (wrapped or clamped)
// BEHAVIOUR
//   - Reset (async, rst_n=0): every stage valid bit 0, accumulator 0, out_valid 0,
//     out_data 0, out_ovf 0. Any partial frame is discarded.
//   - advance = !out_valid | out_ready; in_ready = advance (combinational).
//     A beat is accepted when in_valid & in_ready.
//   - Pipeline: LEVELS tree stages plus one output/accumulate stage. All stages load when
//     advance=1 and hold when advance=0. Each stage carries valid, acc_en and in_last
//     with its data; empty slots (bubbles) travel as valid=0.
//   - Latency: a result reaches out_valid LEVELS+1 cycles after acceptance when no stall
//     occurs; throughput is one beat per cycle.
//   - Tree level j pairs element 2i with element 2i+1 and sign-extends by 1 bit per level.
//     The tree never overflows (TREE_W bits). Every operand 0..N_IN-1 is summed exactly
//     once.
//   - Output stage, valid beat with tree sum s:
//       acc_en=0           : v = s; load out_data and out_ovf; out_valid=1; accumulator
//                            unchanged.
//       acc_en=1, !in_last : acc <= acc + s (ACC_W, wraps); no output; out_valid <= 0
//                            when advancing.
//       acc_en=1,  in_last : v = acc + s; emit v; acc <= 0.
//     A frame's first beat adds to acc=0. An acc_en=0 beat inside an open frame is
//     emitted alone and leaves acc untouched.
//   - Conversion of v (signed):
//       SAT=0: out_data = v[OUT_W-1:0].
//       SAT=1: clamp to 2^(OUT_W-1)-1 or -2^(OUT_W-1).
//       out_ovf = 1 iff v lies outside [-2^(OUT_W-1), 2^(OUT_W-1)-1], in both modes.
//   - Stall: while out_valid & !out_ready, out_data, out_ovf and all stages hold; no beat
//     is lost or duplicated.
//   - out_valid & out_ready with a new result arriving: the output register reloads in the
//     same cycle, with no bubble. With no new result arriving, out_valid falls to 0.
// TESTING (N_IN=32, IN_W=36, OUT_W=32, ACC_EXT=8)
//   1. acc_en=0, operand k = k+1 (1..32), one beat -> out_data=528 exactly 6 cycles later,
//      out_ovf=0.
//   2. Single-hot beats: only operand 31 = 1, then only operand 30 = 1, then only
//      operand 0 = -5 -> results 1, 1, -5 in order (checks every lane is summed once).
//   3. All operands = 2^30: SAT=0 -> out_data=0x00000000, out_ovf=1.
//      SAT=1 -> 0x7FFFFFFF, out_ovf=1.
//      All operands = -2^30 with SAT=1 -> 0x80000000, out_ovf=1.
//   4. 8 back-to-back beats (sums 1..8), out_ready pattern 1,0,1,0,... -> results 1..8
//      in order, none lost or duplicated; in_ready=0 whenever out_valid & !out_ready.
//   5. acc_en=1: 4 beats of all-ones, in_last on beat 4 -> a single result 128, no output
//      for beats 1-3. Then an acc_en=0 all-ones beat -> 32.
//   6. Reset after 2 accumulated all-ones beats -> outputs 0 immediately. Then a single
//      acc_en=1, in_last=1 all-ones beat -> 32 (no residue from before the reset).

Source files
------------

// File: rtl/pipelined_tree_adder.sv
// pipelined_tree_adder: registered binary-tree reduction of N_IN signed operands per beat,
// with optional frame accumulation and wrap/saturate conversion to OUT_W.
module pipelined_tree_adder #(
    parameter int N_IN    = 32,
    parameter int IN_W    = 36,
    parameter int OUT_W   = 32,
    parameter int ACC_EXT = 8,
    parameter int SAT     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN*IN_W-1:0] in_data,
    input  logic                 in_last,
    input  logic                 acc_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_ovf
);
    localparam int LEVELS = $clog2(N_IN);
    localparam int TREE_W = IN_W + LEVELS;
    localparam int ACC_W  = TREE_W + ACC_EXT;

    logic advance;
    logic out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, s, v;
    logic [ACC_W-OUT_W:0] hi;
    logic ovf, emit, t_v, t_a, t_l;

    assign advance   = !out_valid_q | out_ready;
    assign in_ready  = advance;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

    for (genvar j = 0; j < LEVELS; j++) begin : lvl
        logic v_q, a_q, l_q, v_d, a_d, l_d;
        if (j == 0) begin : ctl0
            assign v_d = in_valid;
            assign a_d = acc_en;
            assign l_d = in_last;
        end else begin : ctln
            assign v_d = lvl[j-1].v_q;
            assign a_d = lvl[j-1].a_q;
            assign l_d = lvl[j-1].l_q;
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                a_q <= 1'b0;
                l_q <= 1'b0;
            end else if (advance) begin
                v_q <= v_d;
                a_q <= a_d;
                l_q <= l_d;
            end
        end
        for (genvar i = 0; i < (N_IN >> (j + 1)); i++) begin : nd
            logic signed [TREE_W-1:0] a, b, q;
            if (j == 0) begin : leaf
                assign a = TREE_W'($signed(in_data[(2*i)*IN_W +: IN_W]));
                assign b = TREE_W'($signed(in_data[(2*i+1)*IN_W +: IN_W]));
            end else begin : inner
                assign a = lvl[j-1].nd[2*i].q;
                assign b = lvl[j-1].nd[2*i+1].q;
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) q <= '0;
                else if (advance) q <= a + b;
            end
        end
    end

    assign t_v = lvl[LEVELS-1].v_q;
    assign t_a = lvl[LEVELS-1].a_q;
    assign t_l = lvl[LEVELS-1].l_q;

    // v is acc+s for accumulating beats, so a closing beat and a mid-frame beat share the adder
    always_comb begin
        s           = ACC_W'(lvl[LEVELS-1].nd[0].q);
        v           = t_a ? acc_q + s : s;
        hi          = v[ACC_W-1:OUT_W-1];
        ovf         = !(&hi || !(|hi));
        emit        = t_v & (!t_a | t_l);
        out_valid_d = emit;
        out_ovf_d   = emit ? ovf : out_ovf_q;
        out_data_d  = !emit ? out_data_q :
                      (SAT != 0 && ovf) ? (v[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}}) :
                      v[OUT_W-1:0];
        acc_d       = (t_v & t_a) ? (t_l ? '0 : v) : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            acc_q       <= '0;
        end else if (advance) begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
            acc_q       <= acc_d;
        end
    end
endmodule

// File: tb/tb_pipelined_tree_adder.sv
// tb_pipelined_tree_adder: scoreboard bench driving a wrapping and a saturating instance
// with identical stimulus and checking each against its own expected-result queue.
module tb_pipelined_tree_adder;
    localparam int N = 32;
    localparam int W = 36;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0, in_last = 1'b0, acc_en = 1'b0, out_ready = 1'b1;
    logic [N*W-1:0] in_data = '0;
    logic in_ready, in_ready_s;
    logic o_valid0, o_valid1, o_ovf0, o_ovf1;
    logic [31:0] o_data0, o_data1;

    int checks = 0;
    int errors = 0;
    longint macc = 0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];

    always #5 clk = ~clk;

    pipelined_tree_adder #(.N_IN(N), .IN_W(W), .OUT_W(32), .ACC_EXT(8), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .acc_en(acc_en), .out_valid(o_valid0), .out_ready(out_ready),
        .out_data(o_data0), .out_ovf(o_ovf0));

    pipelined_tree_adder #(.N_IN(N), .IN_W(W), .OUT_W(32), .ACC_EXT(8), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .in_last(in_last), .acc_en(acc_en), .out_valid(o_valid1), .out_ready(out_ready),
        .out_data(o_data1), .out_ovf(o_ovf1));

    function automatic logic [32:0] conv(input longint v, input bit sat);
        bit ovf;
        logic [31:0] d;
        ovf = (v > 64'sd2147483647) || (v < -64'sd2147483648);
        d = (sat && ovf) ? ((v < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF) : v[31:0];
        return {ovf, d};
    endfunction

    function automatic logic [N*W-1:0] fill(input longint v);
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = v[W-1:0];
        return r;
    endfunction

    function automatic logic [N*W-1:0] one_hot(input int k, input longint v);
        logic [N*W-1:0] r;
        r = '0;
        r[k*W +: W] = v[W-1:0];
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid0 && out_ready) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL wrap_unexpected got data=%h ovf=%b, required no output", o_data0, o_ovf0);
                end else begin
                    logic [32:0] e;
                    e = q0.pop_front();
                    if ({o_ovf0, o_data0} !== e) begin
                        errors++;
                        $display("FAIL wrap_result got data=%h ovf=%b, required data=%h ovf=%b",
                                 o_data0, o_ovf0, e[31:0], e[32]);
                    end
                end
            end
            if (o_valid1 && out_ready) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL sat_unexpected got data=%h ovf=%b, required no output", o_data1, o_ovf1);
                end else begin
                    logic [32:0] e;
                    e = q1.pop_front();
                    if ({o_ovf1, o_data1} !== e) begin
                        errors++;
                        $display("FAIL sat_result got data=%h ovf=%b, required data=%h ovf=%b",
                                 o_data1, o_ovf1, e[31:0], e[32]);
                    end
                end
            end
            if (o_valid0 && !out_ready) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready got %b, required 0", in_ready);
                end
            end
        end
    end

    task automatic send(input logic [N*W-1:0] d, input logic ae, input logic last);
        bit ok;
        int n;
        longint s;
        in_data = d;
        acc_en = ae;
        in_last = last;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 100);
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout got in_ready=0 for %0d cycles, required acceptance", n);
        end else begin
            s = 0;
            for (int k = 0; k < N; k++) s += longint'($signed(d[k*W +: W]));
            if (!ae) begin
                q0.push_back(conv(s, 0));
                q1.push_back(conv(s, 1));
            end else if (last) begin
                q0.push_back(conv(macc + s, 0));
                q1.push_back(conv(macc + s, 1));
                macc = 0;
            end else macc += s;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d/%0d pending, required 0", q0.size(), q1.size());
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({o_valid0, o_data0, o_ovf0, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state got valid=%b data=%h ovf=%b in_ready=%b, required 0 0 0 1",
                     o_valid0, o_data0, o_ovf0, in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [N*W-1:0] d;
        int n;
        for (int k = 0; k < N; k++) d[k*W +: W] = W'(k + 1);
        send(d, 1'b0, 1'b0);
        n = 1;
        while (!o_valid0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL latency got %0d cycles, required 6", n);
        end
        drain();
    endtask

    task automatic test_single_hot();
        send(one_hot(31, 1), 1'b0, 1'b0);
        send(one_hot(30, 1), 1'b0, 1'b0);
        send(one_hot(0, -5), 1'b0, 1'b0);
        for (int k = 1; k < 30; k++) send(one_hot(k, k * 3 - 40), 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_overflow();
        send(fill(longint'(1) << 30), 1'b0, 1'b0);
        send(fill(-(longint'(1) << 30)), 1'b0, 1'b0);
        send(fill(longint'(1) << 20), 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        fork
            for (int n = 1; n <= 8; n++) send(one_hot(0, n), 1'b0, 1'b0);
            begin
                repeat (30) begin
                    @(posedge clk);
                    #1;
                    out_ready = ~out_ready;
                end
                out_ready = 1'b1;
            end
        join
        drain();
    endtask

    task automatic test_accumulate();
        for (int n = 1; n <= 4; n++) send(fill(1), 1'b1, n == 4);
        send(fill(1), 1'b0, 1'b0);
        send(fill(2), 1'b1, 1'b0);
        send(fill(-7), 1'b0, 1'b0);
        send(fill(3), 1'b1, 1'b1);
        drain();
    endtask

    task automatic test_reset_mid_frame();
        send(fill(1), 1'b1, 1'b0);
        send(fill(1), 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({o_valid0, o_data0, o_ovf0} !== 34'h0) begin
            errors++;
            $display("FAIL reset_wrap got valid=%b data=%h ovf=%b, required 0", o_valid0, o_data0, o_ovf0);
        end
        checks++;
        if ({o_valid1, o_data1, o_ovf1} !== 34'h0) begin
            errors++;
            $display("FAIL reset_sat got valid=%b data=%h ovf=%b, required 0", o_valid1, o_data1, o_ovf1);
        end
        macc = 0;
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(fill(1), 1'b1, 1'b1);
        drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_hot();
        test_overflow();
        test_back_to_back();
        test_accumulate();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
